fp8_add_arbiter: RTL

- Shares one combinational `adderFP8` instance among NUM_REQ requesters.
- Round-robin arbitration; each requester has a valid/ready handshake.
- One-entry registered result stage returns the sum tagged with the requester ID, with backpressure.
- Sits between the FP8 compute clients and the single adder, so the adder is instantiated once rather than per client.

---
 rtl/fp8_add_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fp8_add_arbiter.sv
// fp8_add_arbiter: shares one combinational adderFP8 among NUM_REQ requesters.
// Round-robin grant selection, a valid/ready handshake per requester, and a
// one-entry registered result stage with backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  [NUM_REQ]    per-requester operand valid
//   req_ready  [NUM_REQ]    per-requester accept, one-hot or zero
//   req_a      [8*NUM_REQ]  operand A, requester i at [8i+7:8i]
//   req_b      [8*NUM_REQ]  operand B, same packing
//   res_valid  result register holds an unconsumed result
//   res_ready  downstream accepts the result
//   res_c      [8]    FP8 sum
//   res_id     [IDW]  requester that produced res_c
//   op_count   [16]   result handshake counter (only with FP8_ARB_CNT_EN)
//
// Optional feature macro: FP8_ARB_CNT_EN adds the wrapping op_count output.
//
// adderFP8 is defined here so the block is self-contained.
// FP8_TYPE 0 = E4M3 (bias 7), otherwise E5M2 (bias 15). The adder
// truncates, flushes zero-exponent inputs and underflowing results to +0,
// and saturates overflow to the largest exponent below all-ones with an
// all-ones mantissa.

module adderFP8 #(
    parameter int FP8_TYPE = 0
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] c
);
    localparam int EW = (FP8_TYPE == 0) ? 4 : 5;
    localparam int MW = 7 - EW;
    localparam int SW = MW + 2;     // carry bit + hidden bit + mantissa

    logic          s_big, s_small;
    logic [EW-1:0] e_big, e_small;
    logic [MW-1:0] m_big, m_small;
    logic [EW-1:0] diff;
    logic [SW-1:0] sig_big, sig_small, sum;
    int            e_res;

    always_comb begin
        // Order operands by magnitude so the result sign is that of the larger.
        if (a[6:0] >= b[6:0]) begin
            {s_big, e_big, m_big}       = a;
            {s_small, e_small, m_small} = b;
        end else begin
            {s_big, e_big, m_big}       = b;
            {s_small, e_small, m_small} = a;
        end
        sig_big   = (e_big == '0)   ? '0 : {2'b01, m_big};
        sig_small = (e_small == '0) ? '0 : {2'b01, m_small};
        diff      = e_big - e_small;
        sig_small = (int'(diff) >= SW) ? '0 : (sig_small >> diff);

        if (s_big == s_small) sum = sig_big + sig_small;
        else                  sum = sig_big - sig_small;

        e_res = int'(e_big);
        if (sum[SW-1]) begin
            sum   = sum >> 1;
            e_res = e_res + 1;
        end else begin
            for (int i = 0; i < MW + 1; i++) begin
                if (sum != '0 && !sum[SW-2]) begin
                    sum   = sum << 1;
                    e_res = e_res - 1;
                end
            end
        end

        if (sum == '0 || e_res <= 0)
            c = 8'h00;
        else if (e_res >= (2 ** EW) - 1)
            c = {s_big, EW'((2 ** EW) - 2), {MW{1'b1}}};
        else
            c = {s_big, EW'(e_res), sum[MW-1:0]};
    end
endmodule

module fp8_add_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int FP8_TYPE = 0,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [7:0]           res_c,
    output logic [IDW-1:0]       res_id
`ifdef FP8_ARB_CNT_EN
    ,
    output logic [15:0]          op_count
`endif
);
    logic [IDW-1:0] last_gnt;
    logic [IDW-1:0] g;
    logic [IDW-1:0] cand;
    logic           found;
    logic           can_accept;
    logic           transfer;
    logic [7:0]     sum;

    // Search starts one past the previous winner and wraps.
    always_comb begin
        g     = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(last_gnt) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                g     = cand;
            end
        end
    end

    // Output stage refills in the same cycle it drains.
    assign can_accept = !res_valid || res_ready;

    always_comb begin
        req_ready = '0;
        if (can_accept && found && !rst)
            req_ready[g] = 1'b1;
    end

    // req_ready is only ever set at the winner, which is valid by construction.
    assign transfer = |req_ready;

    adderFP8 #(.FP8_TYPE(FP8_TYPE)) u_add (
        .a (req_a[int'(g) * 8 +: 8]),
        .b (req_b[int'(g) * 8 +: 8]),
        .c (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_c     <= '0;
            res_id    <= '0;
            last_gnt  <= IDW'(NUM_REQ - 1);
        end else if (transfer) begin
            res_valid <= 1'b1;
            res_c     <= sum;
            res_id    <= g;
            last_gnt  <= g;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef FP8_ARB_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            op_count <= '0;
        else if (res_valid && res_ready)
            op_count <= op_count + 16'd1;
    end
`endif
endmodule
